// File: rtl/vga_timing_ctrl.sv
// 640x480@60 Hz VGA timing generator: free-running pixel/line counters with
// combinational sync, pixel-request and colour-gating decodes.
module vga_timing_ctrl #(
   parameter logic [9:0] H_SYNC   = 10'd96,
   parameter logic [9:0] H_BACK   = 10'd40,
   parameter logic [9:0] H_LEFT   = 10'd8,
   parameter logic [9:0] H_VALID  = 10'd640,
   parameter logic [9:0] H_RIGHT  = 10'd8,
   parameter logic [9:0] H_FRONT  = 10'd8,
   parameter logic [9:0] V_SYNC   = 10'd2,
   parameter logic [9:0] V_BACK   = 10'd25,
   parameter logic [9:0] V_TOP    = 10'd8,
   parameter logic [9:0] V_VALID  = 10'd480,
   parameter logic [9:0] V_BOTTOM = 10'd8,
   parameter logic [9:0] V_FRONT  = 10'd2,
   parameter logic       SYNC_POL = 1'b1
) (
   input  logic        vga_clk,
   input  logic        sys_rst_n,
   input  logic [15:0] pix_data,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic        hsync,
   output logic        vsync,
   output logic [15:0] rgb,
   output logic        frame_start
);

   localparam logic [9:0] H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
   localparam logic [9:0] V_TOTAL = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
   localparam logic [9:0] HS0     = H_SYNC + H_BACK + H_LEFT;
   localparam logic [9:0] HE      = HS0 + H_VALID;
   localparam logic [9:0] VS0     = V_SYNC + V_BACK + V_TOP;
   localparam logic [9:0] VE      = VS0 + V_VALID;

   logic [9:0] cnt_h;
   logic [9:0] cnt_v;
   logic       h_last;
   logic       v_last;
   logic       v_act;
   logic       pix_req;
   logic       rgb_valid;

   assign h_last = (cnt_h == H_TOTAL - 10'd1);
   assign v_last = (cnt_v == V_TOTAL - 10'd1);

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_h       <= '0;
         cnt_v       <= '0;
         frame_start <= 1'b0;
      end else begin
         // NOTE: non-blocking so frame_start and cnt_v both see the pre-edge counter values.
         frame_start <= h_last && v_last;
         if (h_last) begin
            cnt_h <= '0;
            cnt_v <= v_last ? 10'd0 : cnt_v + 10'd1;
         end else begin
            cnt_h <= cnt_h + 10'd1;
         end
      end
   end

   assign hsync = (cnt_h < H_SYNC) ? SYNC_POL : ~SYNC_POL;
   assign vsync = (cnt_v < V_SYNC) ? SYNC_POL : ~SYNC_POL;

   // The request window leads the colour window by one clock to absorb the
   // pixel generator's register stage.
   assign v_act     = (cnt_v >= VS0) && (cnt_v < VE);
   assign pix_req   = v_act && (cnt_h >= HS0 - 10'd1) && (cnt_h < HE - 10'd1);
   assign rgb_valid = v_act && (cnt_h >= HS0) && (cnt_h < HE);

   assign pix_x = pix_req ? cnt_h - (HS0 - 10'd1) : 10'h3FF;
   assign pix_y = pix_req ? cnt_v - VS0 : 10'h3FF;
   assign rgb   = rgb_valid ? pix_data : 16'h0000;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a full-size instance for line-level timing and a
// shrunken instance for frame-level behaviour, both against a time-based model.
module tb_vga_timing_ctrl;

   typedef struct {
      logic        hs;
      logic        vs;
      logic [9:0]  px;
      logic [9:0]  py;
      logic [15:0] rgb;
      logic        fs;
   } exp_t;

   typedef struct {
      int          t;
      logic        hs;
      logic        vs;
      logic [9:0]  px;
      logic [9:0]  py;
      logic        on;
      logic [9:0]  rx;
      logic [9:0]  ry;
      logic        fs;
   } vec_t;

   // Shrunken timing for the frame-level instance: 20 clocks/line, 12 lines/frame.
   localparam int B_HSY = 4, B_HBK = 3, B_HL = 1, B_HV = 8, B_HR = 1, B_HF = 3;
   localparam int B_VSY = 2, B_VBK = 2, B_VT = 1, B_VV = 4, B_VB = 1, B_VF = 2;
   localparam int B_HS0 = B_HSY + B_HBK + B_HL;
   localparam int B_HT  = B_HS0 + B_HV + B_HR + B_HF;
   localparam int B_VS0 = B_VSY + B_VBK + B_VT;
   localparam int B_VTT = B_VS0 + B_VV + B_VB + B_VF;

   logic        clk = 1'b0;
   logic        rst_a_n, rst_b_n;
   logic [15:0] pix_data_a, pix_data_b, rgb_a, rgb_b;
   logic [9:0]  pix_x_a, pix_y_a, pix_x_b, pix_y_b;
   logic        hsync_a, vsync_a, frame_start_a, hsync_b, vsync_b, frame_start_b;

   logic [15:0] key;
   int          t_a, t_b;
   int          n_checks = 0, n_fail = 0;
   int          mis_a = 0, mis_b = 0, win_a = 0, win_b = 0, n_steps = 0;
   string       det_a = "", det_b = "";
   bit          cnt_en_a = 1'b0, b_rand_en = 1'b0, done = 1'b0;
   int          hs_hi = 0, vs_hi = 0, fs_cnt = 0, fs_first = -1;
   vec_t        tbl[16];

   always #5 clk = ~clk;

   vga_timing_ctrl u_a (
      .vga_clk(clk), .sys_rst_n(rst_a_n), .pix_data(pix_data_a),
      .pix_x(pix_x_a), .pix_y(pix_y_a), .hsync(hsync_a), .vsync(vsync_a),
      .rgb(rgb_a), .frame_start(frame_start_a)
   );

   vga_timing_ctrl #(
      .H_SYNC(10'(B_HSY)), .H_BACK(10'(B_HBK)), .H_LEFT(10'(B_HL)), .H_VALID(10'(B_HV)),
      .H_RIGHT(10'(B_HR)), .H_FRONT(10'(B_HF)), .V_SYNC(10'(B_VSY)), .V_BACK(10'(B_VBK)),
      .V_TOP(10'(B_VT)), .V_VALID(10'(B_VV)), .V_BOTTOM(10'(B_VB)), .V_FRONT(10'(B_VF)),
      .SYNC_POL(1'b1)
   ) u_b (
      .vga_clk(clk), .sys_rst_n(rst_b_n), .pix_data(pix_data_b),
      .pix_x(pix_x_b), .pix_y(pix_y_b), .hsync(hsync_b), .vsync(vsync_b),
      .rgb(rgb_b), .frame_start(frame_start_b)
   );

   function automatic logic [15:0] pat(logic [9:0] x, logic [9:0] y);
      return {x[4:0], y[5:0], x[4:0]} ^ key;
   endfunction

   // Pixel generators: one registered stage from request to data.
   always @(posedge clk) begin
      pix_data_a <= pat(pix_x_a, pix_y_a);
      pix_data_b <= pat(pix_x_b, pix_y_b);
   end

   // Clocks elapsed since reset release; the model derives everything from this.
   always @(posedge clk or negedge rst_a_n) begin
      if (!rst_a_n) t_a <= 0;
      else          t_a <= t_a + 1;
   end
   always @(posedge clk or negedge rst_b_n) begin
      if (!rst_b_n) t_b <= 0;
      else          t_b <= t_b + 1;
   end

   function automatic exp_t model(int t, int hsy, int hs0, int hv, int ht,
                                  int vsy, int vs0, int vv, int vt);
      exp_t e;
      int   h, v;
      bit   vin, req, val;
      h   = t % ht;
      v   = (t / ht) % vt;
      vin = (v >= vs0) && (v < vs0 + vv);
      req = vin && (h >= hs0 - 1) && (h < hs0 + hv - 1);
      val = vin && (h >= hs0) && (h < hs0 + hv);
      e.hs  = (h < hsy);
      e.vs  = (v < vsy);
      e.px  = req ? 10'(h - hs0 + 1) : 10'h3FF;
      e.py  = req ? 10'(v - vs0) : 10'h3FF;
      e.rgb = val ? pat(10'(h - hs0), 10'(v - vs0)) : 16'h0000;
      e.fs  = (t > 0) && ((t % (ht * vt)) == 0);
      return e;
   endfunction

   function automatic string diff(exp_t a, exp_t e);
      if (a.hs  !== e.hs)  return $sformatf("hsync %b want %b", a.hs, e.hs);
      if (a.vs  !== e.vs)  return $sformatf("vsync %b want %b", a.vs, e.vs);
      if (a.px  !== e.px)  return $sformatf("pix_x %0h want %0h", a.px, e.px);
      if (a.py  !== e.py)  return $sformatf("pix_y %0h want %0h", a.py, e.py);
      if (a.rgb !== e.rgb) return $sformatf("rgb %0h want %0h", a.rgb, e.rgb);
      if (a.fs  !== e.fs)  return $sformatf("frame_start %b want %b", a.fs, e.fs);
      return "";
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic flush_a();
      check($sformatf("A model window %s", det_a), 32'(mis_a), 32'd0);
      mis_a = 0; det_a = ""; win_a = 0;
   endtask

   task automatic flush_b();
      check($sformatf("B model window %s", det_b), 32'(mis_b), 32'd0);
      mis_b = 0; det_b = ""; win_b = 0;
   endtask

   // One clock: compare both instances against the model on the falling edge.
   task automatic step();
      exp_t  e, a;
      string d;
      @(negedge clk);
      e = model(t_a, 96, 144, 640, 800, 2, 35, 480, 525);
      a = '{hsync_a, vsync_a, pix_x_a, pix_y_a, rgb_a, frame_start_a};
      d = diff(a, e);
      if (d != "") begin
         if (mis_a == 0) det_a = $sformatf("t=%0d %s", t_a, d);
         mis_a++;
      end
      e = model(t_b, B_HSY, B_HS0, B_HV, B_HT, B_VSY, B_VS0, B_VV, B_VTT);
      a = '{hsync_b, vsync_b, pix_x_b, pix_y_b, rgb_b, frame_start_b};
      d = diff(a, e);
      if (d != "") begin
         if (mis_b == 0) det_b = $sformatf("t=%0d %s", t_b, d);
         mis_b++;
      end
      if (cnt_en_a && t_a >= 1 && t_a <= 1600 && hsync_a === 1'b1) hs_hi++;
      if (cnt_en_a && t_a >= 1 && t_a <= 24000 && vsync_a === 1'b1) vs_hi++;
      if (!b_rand_en && t_b >= 1 && t_b <= 2 * B_HT * B_VTT - 1 && frame_start_b === 1'b1) begin
         if (fs_cnt == 0) fs_first = t_b;
         fs_cnt++;
      end
      n_steps++;
      if (n_steps == 600) b_rand_en = 1'b1;
      win_a++;
      if (win_a == 800) flush_a();
      win_b++;
      if (win_b == B_HT * B_VTT) flush_b();
   endtask

   task automatic advance_to(int target);
      int guard = 0;
      while (t_a != target && guard < 40000) begin
         step();
         guard++;
      end
      if (t_a != target) check("advance timeout", 32'(t_a), 32'(target));
   endtask

   task automatic apply_vec(int i);
      logic [15:0] er;
      er = tbl[i].on ? pat(tbl[i].rx, tbl[i].ry) : 16'h0000;
      check($sformatf("vec%0d t=%0d hsync", i, tbl[i].t), 32'(hsync_a), 32'(tbl[i].hs));
      check($sformatf("vec%0d t=%0d vsync", i, tbl[i].t), 32'(vsync_a), 32'(tbl[i].vs));
      check($sformatf("vec%0d t=%0d pix_x", i, tbl[i].t), 32'(pix_x_a), 32'(tbl[i].px));
      check($sformatf("vec%0d t=%0d pix_y", i, tbl[i].t), 32'(pix_y_a), 32'(tbl[i].py));
      check($sformatf("vec%0d t=%0d rgb", i, tbl[i].t), 32'(rgb_a), 32'(er));
      check($sformatf("vec%0d t=%0d frame_start", i, tbl[i].t), 32'(frame_start_a), 32'(tbl[i].fs));
   endtask

   // Random mid-frame resets on the shrunken instance once its first frames are checked.
   initial begin
      wait (b_rand_en);
      while (!done) begin
         repeat ($urandom_range(30, 700)) @(negedge clk);
         #2 rst_b_n = 1'b0;
         repeat ($urandom_range(1, 4)) @(negedge clk);
         #2 rst_b_n = 1'b1;
      end
   end

   initial begin
      key = 16'($urandom);
      //         t      hs    vs    px       py       on    rx       ry      fs
      tbl[0]  = '{0,     1'b1, 1'b1, 10'h3FF, 10'h3FF, 1'b0, 10'd0,   10'd0,  1'b0};
      tbl[1]  = '{1,     1'b1, 1'b1, 10'h3FF, 10'h3FF, 1'b0, 10'd0,   10'd0,  1'b0};
      tbl[2]  = '{95,    1'b1, 1'b1, 10'h3FF, 10'h3FF, 1'b0, 10'd0,   10'd0,  1'b0};
      tbl[3]  = '{96,    1'b0, 1'b1, 10'h3FF, 10'h3FF, 1'b0, 10'd0,   10'd0,  1'b0};
      tbl[4]  = '{799,   1'b0, 1'b1, 10'h3FF, 10'h3FF, 1'b0, 10'd0,   10'd0,  1'b0};
      tbl[5]  = '{800,   1'b1, 1'b1, 10'h3FF, 10'h3FF, 1'b0, 10'd0,   10'd0,  1'b0};
      tbl[6]  = '{1600,  1'b1, 1'b0, 10'h3FF, 10'h3FF, 1'b0, 10'd0,   10'd0,  1'b0};
      tbl[7]  = '{27700, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 1'b0, 10'd0,   10'd0,  1'b0};
      tbl[8]  = '{28142, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 1'b0, 10'd0,   10'd0,  1'b0};
      tbl[9]  = '{28143, 1'b0, 1'b0, 10'd0,   10'd0,   1'b0, 10'd0,   10'd0,  1'b0};
      tbl[10] = '{28144, 1'b0, 1'b0, 10'd1,   10'd0,   1'b1, 10'd0,   10'd0,  1'b0};
      tbl[11] = '{28782, 1'b0, 1'b0, 10'd639, 10'd0,   1'b1, 10'd638, 10'd0,  1'b0};
      tbl[12] = '{28783, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 1'b1, 10'd639, 10'd0,  1'b0};
      tbl[13] = '{28784, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 1'b0, 10'd0,   10'd0,  1'b0};
      tbl[14] = '{28943, 1'b0, 1'b0, 10'd0,   10'd1,   1'b0, 10'd0,   10'd0,  1'b0};
      tbl[15] = '{29087, 1'b0, 1'b0, 10'd144, 10'd1,   1'b1, 10'd143, 10'd1,  1'b0};

      rst_a_n = 1'b0;
      rst_b_n = 1'b0;
      repeat (5) step();
      apply_vec(0);
      rst_a_n  = 1'b1;
      rst_b_n  = 1'b1;
      cnt_en_a = 1'b1;
      for (int i = 1; i < 16; i++) begin
         advance_to(tbl[i].t);
         apply_vec(i);
      end
      cnt_en_a = 1'b0;

      check("hsync high clocks in 2 lines", 32'(hs_hi), 32'd192);
      // t=1..24000 misses the frame's t=0 clock, so one short of 1600.
      check("vsync high clocks in first 30 lines", 32'(vs_hi), 32'd1599);
      check("B frame_start pulses in 2 frames", 32'(fs_cnt), 32'd1);
      check("B first frame_start time", 32'(fs_first), 32'(B_HT * B_VTT));

      // Mid-frame reset at line 36, column 400.
      advance_to(36 * 800 + 400);
      check("A pix_x before mid reset", 32'(pix_x_a), 32'd257);
      rst_a_n = 1'b0;
      #1;
      check("A async reset hsync", 32'(hsync_a), 32'd1);
      check("A async reset vsync", 32'(vsync_a), 32'd1);
      check("A async reset pix_x", 32'(pix_x_a), 32'h3FF);
      check("A async reset pix_y", 32'(pix_y_a), 32'h3FF);
      check("A async reset rgb", 32'(rgb_a), 32'd0);
      check("A async reset frame_start", 32'(frame_start_a), 32'd0);
      repeat (3) step();
      rst_a_n = 1'b1;
      step();
      check("A restart hsync", 32'(hsync_a), 32'd1);
      check("A restart vsync", 32'(vsync_a), 32'd1);
      repeat (1700) step();

      done = 1'b1;
      if (win_a > 0) flush_a();
      if (win_b > 0) flush_b();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
